// File: rtl/cdc_handshake_arbiter.sv
// cdc_handshake_arbiter
// Source-side controller that shares one 4-phase req/ack crossing channel
// among NUM_REQ local requesters. A round-robin pick selects the winner, and
// the winner's payload and index are held on the crossing bus for the whole
// handshake. The ack input is assumed to be synchronized into clk already.
// A per-phase watchdog recovers the channel when the far side goes silent.
module cdc_handshake_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      xfer_req,
   output logic [DATA_W-1:0]         xfer_data,
   output logic [ID_W-1:0]           xfer_id,
   input  logic                      ack_sync,
   output logic                      busy,
   output logic                      timeout_err
);

   // Timer is wide enough to hold TIMEOUT; expiry fires on the TIMEOUT-th
   // cycle spent in a handshake phase.
   localparam int               TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam bit               WD_ON    = (TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      REQ_HI      = 2'd1,
      WAIT_ACK_LO = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic              xfer_req_reg, xfer_req_next;
   logic [DATA_W-1:0] xfer_data_reg, xfer_data_next;
   logic [ID_W-1:0]   xfer_id_reg, xfer_id_next;
   logic [ID_W-1:0]   last_grant_reg, last_grant_next;
   logic [TMR_W-1:0]  timer_reg, timer_next;
   logic              timeout_err_reg, timeout_err_next;

   logic [DATA_W-1:0] req_data_arr [NUM_REQ];
   logic              grant_found;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   cand;

   // Split the packed payload bus into one word per requester.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
   end

   // Round-robin pick: scan from last_grant+1 upward with wrap; scanning in
   // reverse lets the nearest valid index overwrite any farther one.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Next-state, handshake sequencing, watchdog and the accept pulse.
   always_comb begin
      state_next       = state_reg;
      xfer_req_next    = xfer_req_reg;
      xfer_data_next   = xfer_data_reg;
      xfer_id_next     = xfer_id_reg;
      last_grant_next  = last_grant_reg;
      timer_next       = '0;
      timeout_err_next = 1'b0;
      req_ready        = '0;

      case (state_reg)
         IDLE: begin
            // A stale ack from the far side blocks any new request.
            if (!rst && !ack_sync && grant_found) begin
               req_ready[grant_idx] = 1'b1;
               xfer_data_next       = req_data_arr[grant_idx];
               xfer_id_next         = grant_idx;
               last_grant_next      = grant_idx;
               xfer_req_next        = 1'b1;
               state_next           = REQ_HI;
            end
         end

         REQ_HI: begin
            xfer_req_next = 1'b1;
            if (ack_sync) begin
               // Ack takes precedence over a simultaneous expiry.
               xfer_req_next = 1'b0;
               state_next    = WAIT_ACK_LO;
            end else if (WD_ON && timer_reg == TMR_LAST) begin
               // Abandon the transfer; the far side must still release ack.
               timeout_err_next = 1'b1;
               xfer_req_next    = 1'b0;
               state_next       = WAIT_ACK_LO;
            end else if (WD_ON) begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end

         WAIT_ACK_LO: begin
            xfer_req_next = 1'b0;
            if (!ack_sync) begin
               state_next = IDLE;
            end else if (WD_ON && timer_reg == TMR_LAST) begin
               // Keep waiting, but flag every full period of a stuck ack.
               timeout_err_next = 1'b1;
            end else if (WD_ON) begin
               timer_next = timer_reg + TMR_W'(1);
            end
         end

         default: begin
            xfer_req_next = 1'b0;
            state_next    = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         xfer_req_reg    <= 1'b0;
         xfer_data_reg   <= '0;
         xfer_id_reg     <= '0;
         last_grant_reg  <= ID_W'(NUM_REQ - 1);
         timer_reg       <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         xfer_req_reg    <= xfer_req_next;
         xfer_data_reg   <= xfer_data_next;
         xfer_id_reg     <= xfer_id_next;
         last_grant_reg  <= last_grant_next;
         timer_reg       <= timer_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   assign xfer_req    = xfer_req_reg;
   assign xfer_data   = xfer_data_reg;
   assign xfer_id     = xfer_id_reg;
   assign timeout_err = timeout_err_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Self-checking bench for cdc_handshake_arbiter: directed scenarios followed
// by randomized transfers, each checked against a transaction-level model
// (round-robin pick from the last winner, far side acting as a 4-phase peer).
module tb_cdc_handshake_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int IW = 2;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]   req_ready;
   logic            xfer_req;
   logic [DW-1:0]   xfer_data;
   logic [IW-1:0]   xfer_id;
   logic            ack_sync = 1'b0;
   logic            busy;
   logic            timeout_err;

   int              n_pass   = 0;
   int              n_fail   = 0;
   int              n_checks = 0;
   int              model_last;
   logic [NR-1:0]   vld;
   logic [31:0]     dat;
   int              got;
   int              w;

   cdc_handshake_arbiter #(
      .NUM_REQ(NR),
      .DATA_W (DW),
      .ID_W   (IW),
      .TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .xfer_req   (xfer_req),
      .xfer_data  (xfer_data),
      .xfer_id    (xfer_id),
      .ack_sync   (ack_sync),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: first valid requester after the previous winner, wrapping.
   function automatic int rr_pick(input logic [NR-1:0] v, input int last);
      int c;
      for (int k = 1; k <= NR; k++) begin
         c = (last + k) % NR;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // One full transaction from IDLE: grant, hold, ack after ad cycles,
   // release ack rel cycles after xfer_req falls. Returns observed xfer_id.
   task automatic do_xfer(input int ad, input int rel, input bit drop, output int id_seen);
      int          win;
      logic [DW-1:0] d;
      req_valid = vld;
      req_data  = dat;
      ack_sync  = 1'b0;
      #1;
      win = rr_pick(vld, model_last);
      id_seen = -1;
      if (win < 0) begin
         chk("idle_rdy", req_ready, 0);
         tick();
         chk("idle_busy", busy, 0);
         chk("idle_xreq", xfer_req, 0);
         $display("xfer: valid=%b no grant", vld);
         return;
      end
      chk("grant_rdy", req_ready, 32'(1) << win);
      d = dat[win*DW +: DW];
      model_last = win;
      tick();
      if (drop) vld[win] = 1'b0;
      req_valid = vld;
      dat       = $urandom;
      req_data  = dat;
      #1;
      id_seen = int'(xfer_id);
      chk("xreq_rise", xfer_req, 1);
      chk("xfer_id", xfer_id, win);
      chk("xfer_data", xfer_data, d);
      chk("busy_hi", busy, 1);
      chk("rdy_in_xfer", req_ready, 0);
      repeat (ad) begin
         tick();
         chk("xreq_hold", xfer_req, 1);
         chk("data_hold", xfer_data, d);
      end
      ack_sync = 1'b1;
      tick();
      chk("xreq_fall", xfer_req, 0);
      chk("no_timeout", timeout_err, 0);
      repeat (rel) begin
         tick();
         chk("wait_busy", busy, 1);
         chk("wait_xreq", xfer_req, 0);
         chk("wait_rdy", req_ready, 0);
         chk("wait_data", xfer_data, d);
      end
      ack_sync = 1'b0;
      tick();
      chk("done_busy", busy, 0);
      chk("done_id", xfer_id, win);
      chk("done_data", xfer_data, d);
      $display("xfer: grant=%0d id=%0d data=%02h ack_dly=%0d rel_dly=%0d", win, id_seen, d, ad, rel);
   endtask

   initial begin
      // Reset state
      #1;
      rst = 1'b1;
      #1;
      chk("rst_xreq", xfer_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdy", req_ready, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_data", xfer_data, 0);
      chk("rst_id", xfer_id, 0);
      tick();
      tick();
      rst = 1'b0;
      model_last = NR - 1;

      // Round-robin fairness with all requesters held high
      vld = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         dat = $urandom;
         do_xfer(1 + (i % 3), 1 + (i % 2), 1'b0, got);
         chk("rr_order", got, i % NR);
      end

      // Sparse wrap from last grant 3
      vld = 4'b1001;
      dat = $urandom;
      do_xfer(2, 1, 1'b1, got);
      chk("wrap_first", got, 0);
      dat = $urandom;
      do_xfer(1, 2, 1'b1, got);
      chk("wrap_second", got, 3);

      // Single transfer: requester 2 carrying A5
      vld = 4'b0100;
      dat = 32'h00A5_0000;
      do_xfer(3, 3, 1'b1, got);
      chk("single_id", got, 2);
      do_xfer(2, 2, 1'b1, got);
      chk("single_once", got, -1);

      // Stale ack blocks grants until it falls
      vld       = 4'b0001;
      dat       = $urandom;
      req_valid = vld;
      req_data  = dat;
      ack_sync  = 1'b1;
      repeat (3) begin
         #1;
         chk("stale_rdy", req_ready, 0);
         tick();
         chk("stale_xreq", xfer_req, 0);
         chk("stale_busy", busy, 0);
      end
      do_xfer(1, 1, 1'b1, got);
      chk("stale_grant", got, 0);

      // Watchdog: far side never acks
      vld       = 4'b0110;
      dat       = $urandom;
      req_valid = vld;
      req_data  = dat;
      ack_sync  = 1'b0;
      #1;
      w = rr_pick(vld, model_last);
      chk("to_rdy", req_ready, 32'(1) << w);
      model_last = w;
      tick();
      vld[w]    = 1'b0;
      req_valid = vld;
      #1;
      chk("to_id", xfer_id, 1);
      chk("to_xreq", xfer_req, 1);
      for (int i = 1; i < TO; i++) begin
         tick();
         chk("to_wait_req", xfer_req, 1);
         chk("to_wait_err", timeout_err, 0);
      end
      tick();
      chk("to_err", timeout_err, 1);
      chk("to_xreq_drop", xfer_req, 0);
      chk("to_busy", busy, 1);
      tick();
      chk("to_err_pulse", timeout_err, 0);
      chk("to_idle", busy, 0);
      $display("xfer: timeout on requester %0d", w);
      dat = $urandom;
      do_xfer(2, 2, 1'b1, got);
      chk("to_next", got, 2);

      // Reset during REQ_HI drops xfer_req without a clock edge
      vld       = 4'b1000;
      dat       = $urandom;
      req_valid = vld;
      req_data  = dat;
      #1;
      tick();
      chk("pre_rst_xreq", xfer_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_xreq", xfer_req, 0);
      chk("async_busy", busy, 0);
      chk("async_rdy", req_ready, 0);
      chk("async_id", xfer_id, 0);
      tick();
      tick();
      rst = 1'b0;
      model_last = NR - 1;
      $display("xfer: reset mid-handshake");
      vld = 4'b1111;
      dat = $urandom;
      do_xfer(1, 1, 1'b1, got);
      chk("rst_prio", got, 0);

      // Randomized transfers
      for (int i = 0; i < 40; i++) begin
         vld = 4'($urandom_range(0, 15));
         dat = $urandom;
         do_xfer(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                 1'($urandom_range(0, 1)), got);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
